// File: rtl/sft_seq.sv
// -----------------------------------------------------------------------------
// sft_seq : command sequencer feeding the 74HC595 shift-register driver.
//
// Software fills an internal byte buffer while the block is idle, then pulses
// start. The block then emits the driver command stream:
//   [master reset] -> len x shift-byte (buf[len-1] first, buf[0] last)
//   -> storage latch -> [output enable]
// and pulses finish when the stream is complete.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   wr_en/addr/data buffer write port (accepted only while idle)
//   start           single-cycle pulse that begins a sequence
//   len             bytes to shift (0..DEPTH, larger values clamp to DEPTH)
//   do_mr, do_oe    include master-reset / output-enable commands
//   oen_val         value carried by the output-enable command
//   busy            sequence in progress
//   finish          single-cycle completion pulse
//   err             sequence aborted on a driver timeout (sticky)
//   sft_vld         command strobe to the driver
//   sft_cmd         00 master reset, 01 shift byte, 10 latch, 11 output enable
//   sft_cmd_oen     OE value for command 11
//   sft_din         data byte for command 01
//   sft_done        driver done pulse (only for commands 01 and 10)
//   dbg_state       current FSM state, for observation only
//
// Driver handshake: sft_vld is a one-cycle strobe that carries sft_cmd,
// sft_din and sft_cmd_oen; the driver accepts every strobe unconditionally.
// For commands 01 and 10 the next strobe is withheld until a one-cycle
// sft_done is seen in the matching WAIT state; sft_done anywhere else is
// ignored. Commands 00 and 11 complete without a done pulse. sft_vld is
// never high on two consecutive cycles.
//
// Optional build macro SFT_SEQ_TIMEOUT_EN: bounds each WAIT state to TIMEOUT
// cycles; on expiry the sequence ends via FIN with err set. Without it the
// WAIT states wait forever and err is constant 0.
// -----------------------------------------------------------------------------
module sft_seq #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          do_mr,
  input  logic          do_oe,
  input  logic          oen_val,
  output logic          busy,
  output logic          finish,
  output logic          err,
  output logic          sft_vld,
  output logic [1:0]    sft_cmd,
  output logic          sft_cmd_oen,
  output logic [7:0]    sft_din,
  input  logic          sft_done,
  output logic [3:0]    dbg_state
);

  if (((1 << AW) != DEPTH) || (TIMEOUT < 1)) begin : g_param_check
    $error("sft_seq: DEPTH must equal 2**AW and TIMEOUT must be positive");
  end

  typedef enum logic [3:0] {
    S_IDLE,
    S_MR,
    S_MR_GAP,
    S_SHIFT,
    S_SHIFT_WAIT,
    S_LATCH,
    S_LATCH_WAIT,
    S_OE,
    S_FIN
  } state_t;

  localparam logic [1:0] CMD_MR    = 2'b00;
  localparam logic [1:0] CMD_SHIFT = 2'b01;
  localparam logic [1:0] CMD_LATCH = 2'b10;
  localparam logic [1:0] CMD_OE    = 2'b11;

  state_t        state_q;
  logic          busy_q;
  logic          fin_q;
  logic          vld_q;
  logic [1:0]    cmd_q;
  logic          oen_q;
  logic [7:0]    din_q;
  logic [AW-1:0] idx_q;
  logic          len_nz_q;
  logic          oe_q;
  logic          oenv_q;
  logic [7:0]    mem_q [DEPTH];

  logic [AW:0]   len_clamp;
  logic [AW-1:0] idx_init;
  logic [AW-1:0] idx_dec;

  // Oversized len values saturate at the buffer depth.
  assign len_clamp = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
  // First byte shifted is the farthest one; only meaningful when len_clamp != 0.
  assign idx_init  = AW'(len_clamp - (AW+1)'(1));
  assign idx_dec   = idx_q - AW'(1);

  // Buffer is frozen while a sequence runs so the shifted data is coherent.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

`ifdef SFT_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      fin_q    <= 1'b0;
      vld_q    <= 1'b0;
      cmd_q    <= CMD_MR;
      oen_q    <= 1'b1;
      din_q    <= 8'h00;
      idx_q    <= '0;
      len_nz_q <= 1'b0;
      oe_q     <= 1'b0;
      oenv_q   <= 1'b1;
`ifdef SFT_SEQ_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      // Strobe and finish are one-cycle pulses unless re-raised below.
      vld_q <= 1'b0;
      fin_q <= 1'b0;
`ifdef SFT_SEQ_TIMEOUT_EN
      if (vld_q) begin
        cnt_q <= '0;
      end
`endif
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q   <= 1'b1;
            oe_q     <= do_oe;
            oenv_q   <= oen_val;
            len_nz_q <= (len_clamp != '0);
            idx_q    <= idx_init;
`ifdef SFT_SEQ_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
            vld_q    <= 1'b1;
            if (do_mr) begin
              state_q <= S_MR;
              cmd_q   <= CMD_MR;
            end else if (len_clamp != '0) begin
              state_q <= S_SHIFT;
              cmd_q   <= CMD_SHIFT;
              din_q   <= mem_q[idx_init];
            end else begin
              state_q <= S_LATCH;
              cmd_q   <= CMD_LATCH;
            end
          end
        end
        S_MR: begin
          // Master reset has no done pulse; one idle gap cycle follows it.
          state_q <= S_MR_GAP;
        end
        S_MR_GAP: begin
          vld_q <= 1'b1;
          if (len_nz_q) begin
            state_q <= S_SHIFT;
            cmd_q   <= CMD_SHIFT;
            din_q   <= mem_q[idx_q];
          end else begin
            state_q <= S_LATCH;
            cmd_q   <= CMD_LATCH;
          end
        end
        S_SHIFT: begin
          state_q <= S_SHIFT_WAIT;
        end
        S_SHIFT_WAIT: begin
          if (sft_done) begin
            vld_q <= 1'b1;
            if (idx_q != '0) begin
              state_q <= S_SHIFT;
              cmd_q   <= CMD_SHIFT;
              idx_q   <= idx_dec;
              din_q   <= mem_q[idx_dec];
            end else begin
              state_q <= S_LATCH;
              cmd_q   <= CMD_LATCH;
            end
          end
`ifdef SFT_SEQ_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q <= S_FIN;
            fin_q   <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        S_LATCH: begin
          state_q <= S_LATCH_WAIT;
        end
        S_LATCH_WAIT: begin
          if (sft_done) begin
            if (oe_q) begin
              state_q <= S_OE;
              vld_q   <= 1'b1;
              cmd_q   <= CMD_OE;
              oen_q   <= oenv_q;
            end else begin
              state_q <= S_FIN;
              fin_q   <= 1'b1;
            end
          end
`ifdef SFT_SEQ_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q <= S_FIN;
            fin_q   <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        S_OE: begin
          state_q <= S_FIN;
          fin_q   <= 1'b1;
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign finish      = fin_q;
  assign sft_vld     = vld_q;
  assign sft_cmd     = cmd_q;
  assign sft_cmd_oen = oen_q;
  assign sft_din     = din_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sft_seq.sv
// -----------------------------------------------------------------------------
// tb_sft_seq : self-checking bench for sft_seq.
// A reference model turns (len, do_mr, do_oe, oen_val, buffer contents) into
// the list of strobes with their cycle offsets from start, plus the finish
// offset. A compare process checks strobe/finish/busy/err on every cycle of a
// run. A driver model answers cmd 01/10 with done 31 cycles after the strobe.
// -----------------------------------------------------------------------------
module tb_sft_seq;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TO    = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          start;
  logic [AW:0]   len;
  logic          do_mr;
  logic          do_oe;
  logic          oen_val;
  logic          busy;
  logic          finish;
  logic          err;
  logic          sft_vld;
  logic [1:0]    sft_cmd;
  logic          sft_cmd_oen;
  logic [7:0]    sft_din;
  logic          sft_done;
  logic [3:0]    dbg_state;

  sft_seq #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .do_mr(do_mr), .do_oe(do_oe), .oen_val(oen_val),
    .busy(busy), .finish(finish), .err(err), .sft_vld(sft_vld),
    .sft_cmd(sft_cmd), .sft_cmd_oen(sft_cmd_oen), .sft_din(sft_din),
    .sft_done(sft_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter / driver model ----------------
  always #5 clk = ~clk;

  int cyc     = 0;
  int done_at = -1;
  bit silent  = 1'b0;

  initial begin
    sft_done = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      sft_done = (done_at == cyc);
    end
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    int         t;
    logic [1:0] cmd;
    logic [7:0] din;
    logic       oen;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] buf_m [DEPTH];
  int         t0, fin_off, fin_seen;
  bit         exp_err;
  bit         chk_on   = 1'b0;
  bit         run_done = 1'b0;
  bit         din_seen;
  logic [7:0] first_din;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic void add_ev(input int t, input logic [1:0] c, input logic [7:0] d, input logic o);
    ev_t e;
    e.t = t; e.cmd = c; e.din = d; e.oen = o;
    exp_q.push_back(e);
  endfunction

  // Reference model: strobe schedule derived from command order and the
  // fixed driver timing (32 cycles per shift/latch, MR followed by one gap).
  function automatic void build(input int ln, input bit mr, input bit oe, input bit oen, input bit sil);
    int t = 1;
    int l = (ln > DEPTH) ? DEPTH : ln;
    exp_q.delete();
    exp_err = 1'b0;
    if (mr) begin add_ev(t, 2'b00, 8'h00, 1'b0); t += 2; end
    for (int i = l - 1; i >= 0; i--) begin
      add_ev(t, 2'b01, buf_m[i], 1'b0);
      if (sil) begin fin_off = t + 1 + TO; exp_err = 1'b1; return; end
      t += 32;
    end
    add_ev(t, 2'b10, 8'h00, 1'b0);
    if (sil) begin fin_off = t + 1 + TO; exp_err = 1'b1; return; end
    t += 32;
    if (oe) begin add_ev(t, 2'b11, 8'h00, oen); t += 1; end
    fin_off = t;
  endfunction

  // ---------------- compare process + driver scheduling ----------------
  initial begin
    int  off;
    bit  ev;
    forever begin
      @(negedge clk);
      if (sft_vld && (sft_cmd == 2'b01 || sft_cmd == 2'b10) && !silent) done_at = cyc + 31;
      if (chk_on && !run_done) begin
        off = cyc - t0;
        if (off >= 1) begin
          ev = (exp_q.size() > 0) && (exp_q[0].t == off);
          check("sft_vld", {31'd0, sft_vld}, {31'd0, ev});
          if (ev) begin
            if (sft_vld) begin
              check("sft_cmd", {30'd0, sft_cmd}, {30'd0, exp_q[0].cmd});
              if (exp_q[0].cmd == 2'b01) begin
                check("sft_din", {24'd0, sft_din}, {24'd0, exp_q[0].din});
                if (!din_seen) begin first_din = sft_din; din_seen = 1'b1; end
              end
              if (exp_q[0].cmd == 2'b11)
                check("sft_cmd_oen", {31'd0, sft_cmd_oen}, {31'd0, exp_q[0].oen});
            end
            void'(exp_q.pop_front());
          end
          check("finish", {31'd0, finish}, {31'd0, (off == fin_off)});
          if (finish && fin_seen < 0) fin_seen = off;
          check("busy", {31'd0, busy}, {31'd0, (off <= fin_off)});
          check("err", {31'd0, err}, {31'd0, (exp_err && off >= fin_off)});
          if (off == fin_off + 1) run_done = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input int a, input logic [7:0] d);
    @(posedge clk); #2;
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    @(posedge clk); #2;
    wr_en = 1'b0;
    buf_m[a] = d;
  endtask

  task automatic run(input int ln, input bit mr, input bit oe, input bit oen,
                     input bit sil, input bit interfere, output int fs);
    build(ln, mr, oe, oen, sil);
    silent   = sil;
    fin_seen = -1;
    din_seen = 1'b0;
    @(posedge clk); #2;
    start = 1'b1; len = (AW+1)'(ln); do_mr = mr; do_oe = oe; oen_val = oen;
    t0 = cyc; run_done = 1'b0; chk_on = 1'b1;
    @(posedge clk); #2;
    // Flip the sampled inputs to show they were captured on start.
    start = 1'b0; len = '0; do_mr = ~mr; do_oe = ~oe; oen_val = ~oen;
    for (int k = 0; k < fin_off + 20 && !run_done; k++) begin
      if (interfere && (cyc - t0 == 5)) begin
        wr_en = 1'b1; wr_addr = '0; wr_data = 8'h00; start = 1'b1; len = 1;
      end else begin
        wr_en = 1'b0; start = 1'b0;
      end
      @(posedge clk); #2;
    end
    wr_en = 1'b0; start = 1'b0;
    check("run_completes", {31'd0, run_done}, 32'd1);
    chk_on = 1'b0;
    check("strobes_left", exp_q.size(), 32'd0);
    silent = 1'b0;
    fs = fin_seen;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},   {31'd0, busy},        32'd0);
    check({tag, "_finish"}, {31'd0, finish},      32'd0);
    check({tag, "_err"},    {31'd0, err},         32'd0);
    check({tag, "_vld"},    {31'd0, sft_vld},     32'd0);
    check({tag, "_cmd"},    {30'd0, sft_cmd},     32'd0);
    check({tag, "_oen"},    {31'd0, sft_cmd_oen}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int fs;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    len = '0; do_mr = 1'b0; do_oe = 1'b0; oen_val = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_values("reset");
    check("reset_din", {24'd0, sft_din}, 32'd0);
    rst = 1'b0;

    // Full sequence: MR, two shifts, latch, OE(on).
    wr(0, 8'hA5);
    wr(1, 8'h3C);
    run(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, fs);
    check("full_finish_at", fs, 32'd100);
    check("full_first_byte", {24'd0, first_din}, 32'h3C);

    // Single byte, no MR, no OE.
    wr(0, 8'hFF);
    run(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fs);
    check("len1_finish_at", fs, 32'd65);
    check("len1_byte", {24'd0, first_din}, 32'hFF);

    // Zero bytes: latch then OE(off).
    run(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, fs);
    check("len0_finish_at", fs, 32'd34);

    // Write and second start while busy are both ignored.
    run(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, fs);
    check("busy_ign_finish_at", fs, 32'd97);
    run(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fs);
    check("buf_kept", {24'd0, first_din}, 32'hFF);

    // len above DEPTH clamps to DEPTH.
    for (int i = 0; i < DEPTH; i++) wr(i, 8'(i * 8'h11 + 8'h01));
    run(DEPTH + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fs);
    check("clamp_finish_at", fs, 32'd289);
    check("clamp_first_byte", {24'd0, first_din}, 32'h78);

    // Reset in SHIFT_WAIT aborts at once.
    @(posedge clk); #2;
    start = 1'b1; len = 2; do_mr = 1'b0; do_oe = 1'b0;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    done_at = -1;
    #1;
    check_reset_values("midrst");
    @(posedge clk); #2;
    rst = 1'b0;
    run(2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, fs);
    check("post_rst_finish_at", fs, 32'd100);

`ifdef SFT_SEQ_TIMEOUT_EN
    // Silent driver: abort TO cycles after entering SHIFT_WAIT, no latch.
    run(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, fs);
    check("timeout_finish_at", fs, 32'd66);
    check("timeout_err_sticky", {31'd0, err}, 32'd1);
    run(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fs);
    check("err_cleared_finish_at", fs, 32'd65);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sft_seq.md
Name: sft_seq

Overview:
- Command sequencer directly upstream of the 74HC595 shift-register driver in the TWI/GPIO-expander path.
- Software loads a byte pattern into a small internal buffer, then pulses start.
- The block issues the driver command stream in order: optional master reset, N shift-byte commands, storage latch, optional output-enable.
- It paces each command on the driver's done pulse and signals completion to the bus side.

Parameters:
- DEPTH, 8, buffer size in bytes (number of chained '595 devices); power of two, 2..16.
- AW, 3, buffer address width, equal to log2(DEPTH).
- TIMEOUT, 64, cycles to wait for sft_done before abort (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  AW  buffer write address.
- wr_data  in  8  buffer write data.
- start  in  1  begin sequence (single-cycle pulse).
- len  in  AW+1  number of bytes to shift, 0..DEPTH; sampled on start.
- do_mr  in  1  issue master reset first; sampled on start.
- do_oe  in  1  issue output-enable command last; sampled on start.
- oen_val  in  1  value carried with the OE command (0 = outputs on); sampled on start.
- busy  out  1  sequence in progress.
- finish  out  1  single-cycle completion pulse.
- err  out  1  sequence aborted on timeout.
- sft_vld  out  1  command strobe to the driver.
- sft_cmd  out  2  command code: 00 master reset, 01 shift byte, 10 latch, 11 output enable.
- sft_cmd_oen  out  1  OE value for cmd 11.
- sft_din  out  8  byte for cmd 01.
- sft_done  in  1  single-cycle done pulse from the driver; produced only for cmd 01 and cmd 10.

Behaviour:
- Reset: busy=0, finish=0, err=0, sft_vld=0, sft_cmd=00, sft_cmd_oen=1, sft_din=0, state=IDLE. Buffer contents are not reset.
- All outputs are registered.
- Buffer writes are accepted only in IDLE; wr_en while busy is ignored.
- States: IDLE, MR, MR_GAP, SHIFT, SHIFT_WAIT, LATCH, LATCH_WAIT, OE, FIN.
- IDLE: on start, capture len (clamped to DEPTH if larger), do_mr, do_oe and oen_val; clear err; busy=1 from the next cycle.
  - Next state is MR if do_mr=1, else SHIFT if len!=0, else LATCH.
  - start while not IDLE is ignored.
- MR: sft_vld=1 with cmd 00 for one cycle, then MR_GAP for one cycle (no done is expected for this command). Then SHIFT, or LATCH if len=0.
- SHIFT: sft_vld=1, cmd 01, sft_din=buf[idx].
  - idx starts at len-1 and descends, so buf[0] is shifted last and lands in the nearest '595.
  - Then SHIFT_WAIT.
- SHIFT_WAIT: on sft_done, go to SHIFT if idx!=0 (idx decrements), else LATCH. The next strobe appears in the cycle after done.
- LATCH: sft_vld=1, cmd 10, then LATCH_WAIT. On sft_done, go to OE if do_oe=1, else FIN.
- OE: sft_vld=1, cmd 11, sft_cmd_oen=oen_val for one cycle, then FIN.
- FIN: finish=1 for one cycle; busy drops and state returns to IDLE in the next cycle.
- sft_vld is never high for two consecutive cycles. sft_cmd and sft_din hold their last values when sft_vld=0.
- sft_done outside a WAIT state is ignored.
- With the driver as the load, cmd 01 and cmd 10 each occupy exactly 32 cycles from one strobe to the next (done arrives 31 cycles after vld).
- rst mid-sequence aborts immediately to the reset values. No further strobes are issued; the '595 outputs keep their last latched state.

Optional Feature:
- Macro: SFT_SEQ_TIMEOUT_EN.
- Defined:
  - A wait counter clears on every strobe and increments in SHIFT_WAIT and LATCH_WAIT.
  - When it reaches TIMEOUT with no sft_done, the block goes to FIN and sets err=1. err is sticky until the next accepted start.
  - No further strobes are issued after the abort, and finish still pulses.
- Undefined: the WAIT states wait indefinitely; err is tied to 0.

Test Plan:
- Write buf[0]=0xA5, buf[1]=0x3C; start with len=2, do_mr=1, do_oe=1, oen_val=0 at cycle T, driver model attached ->
  - strobes cmd00@T+1, cmd01/0x3C@T+3, cmd01/0xA5@T+35, cmd10@T+67, cmd11/oen=0@T+99;
  - finish@T+100, busy=0@T+101.
- len=1, do_mr=0, do_oe=0, buf[0]=0xFF, start@T -> cmd01/0xFF@T+1, cmd10@T+33, finish@T+65; no cmd00 or cmd11 strobe.
- len=0, do_oe=1 -> no cmd01; cmd10@T+1, cmd11@T+33, finish@T+34.
- wr_en with 0x00 to addr 0 while busy, then a second start mid-sequence -> buffer unchanged (next run shifts the old value); the second start has no effect.
- SFT_SEQ_TIMEOUT_EN defined, TIMEOUT=64, driver silent after the first cmd01 -> err=1 and finish 64 cycles after the WAIT entry; no cmd10 strobe. The next start clears err.
- Assert rst during SHIFT_WAIT -> sft_vld=0 and busy=0 immediately; a new start after reset runs the full sequence correctly.
